// File: rtl/instr_ram.sv
`default_nettype none
// ============================================================================
//  Module   : instr_ram
//  Purpose  : Single-port synchronous word RAM, instruction/data store of
//             Processor Z. Registered read data, one-cycle latency.
//             Optional macro RAM_WR_BYPASS_EN selects write-first behaviour
//             on a simultaneous write+read; the default build is read-first.
//  Revision : 1.0  initial release
// ============================================================================
module instr_ram #(
    parameter int AW    = 9,
    parameter int DW    = 32,
    parameter int DEPTH = 512
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    input  logic          wr,
    input  logic [DW-1:0] wdata,
    input  logic          rd,
    output logic [DW-1:0] rdata
);

    localparam int          c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [DW-1:0]      r_mem [0:DEPTH-1];
    logic [DW-1:0]      r_rdata;
    logic               w_in_range;
    logic [c_idx_w-1:0] w_idx;

    // Addresses at or above DEPTH never touch storage.
    assign w_in_range = ({1'b0, addr} < c_depth);
    assign w_idx      = addr[c_idx_w-1:0];

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clock) begin
        if (!reset && wr && w_in_range) begin
            r_mem[w_idx] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (rd) begin
            if (!w_in_range) begin
                r_rdata <= '0;
`ifdef RAM_WR_BYPASS_EN
            end else if (wr) begin
                r_rdata <= wdata;
`endif
            end else begin
                r_rdata <= r_mem[w_idx];
            end
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_instr_ram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_ram
//  Purpose  : Self-checking bench for instr_ram: directed program load/fetch,
//             hold, collision, reset and boundary cases, then random traffic
//             compared against an array-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_ram;

    logic        clock;
    logic        reset;
    logic [8:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic        rd;
    logic [31:0] rdata_full;
    logic [31:0] rdata_500;

    int n_cmp;
    int n_bad;

    // Reference state for the full-depth and the 500-word instance.
    logic [31:0] m_full [512];
    bit          k_full [512];
    logic [31:0] m_500  [512];
    bit          k_500  [512];
    logic [31:0] e_full, e_500;
    bit          ek_full, ek_500;

    instr_ram #(.AW(9), .DW(32), .DEPTH(512)) u_dut_full (
        .clock (clock), .reset (reset), .addr (addr), .wr (wr),
        .wdata (wdata), .rd (rd), .rdata (rdata_full)
    );

    instr_ram #(.AW(9), .DW(32), .DEPTH(500)) u_dut_500 (
        .clock (clock), .reset (reset), .addr (addr), .wr (wr),
        .wdata (wdata), .rd (rd), .rdata (rdata_500)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected read result for one RAM of the given depth, before the write lands.
    task automatic model_read(input int depth, input logic w, input logic [8:0] a,
                              input logic [31:0] d, input logic [31:0] mem_val,
                              input bit mem_known, output logic [31:0] e, output bit ek);
        if (int'(a) >= depth) begin
            e = 32'h0; ek = 1'b1;
        end else begin
`ifdef RAM_WR_BYPASS_EN
            if (w) begin
                e = d; ek = 1'b1;
            end else begin
                e = mem_val; ek = mem_known;
            end
`else
            e = mem_val; ek = mem_known;
`endif
        end
    endtask

    // Drive one cycle, advance one edge, update the model and compare.
    task automatic step(input logic rst, input logic w, input logic r,
                        input logic [8:0] a, input logic [31:0] d);
        reset = rst; wr = w; rd = r; addr = a; wdata = d;
        @(posedge clock);
        #1;
        if (rst) begin
            e_full = 32'h0; ek_full = 1'b1;
            e_500  = 32'h0; ek_500  = 1'b1;
        end else begin
            if (r) begin
                model_read(512, w, a, d, m_full[a], k_full[a], e_full, ek_full);
                model_read(500, w, a, d, m_500[a],  k_500[a],  e_500,  ek_500);
            end
            if (w) begin
                m_full[a] = d; k_full[a] = 1'b1;
                if (int'(a) < 500) begin
                    m_500[a] = d; k_500[a] = 1'b1;
                end
            end
        end
        if (ek_full) check("model_full", rdata_full, e_full);
        if (ek_500)  check("model_500", rdata_500, e_500);
    endtask

    logic [31:0] prog [5];

    initial begin
        n_cmp = 0; n_bad = 0;
        ek_full = 1'b0; ek_500 = 1'b0;
        e_full = '0; e_500 = '0;
        for (int i = 0; i < 512; i++) begin
            k_full[i] = 1'b0; k_500[i] = 1'b0;
            m_full[i] = '0;   m_500[i] = '0;
        end
        prog[0] = 32'h10f00010; prog[1] = 32'h20010000; prog[2] = 32'h21230000;
        prog[3] = 32'h22450000; prog[4] = 32'h23670000;
        reset = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;

        @(posedge clock); #1;
        step(1'b1, 1'b0, 1'b1, 9'(($urandom % 512)), 32'h0);
        check("reset_rdata", rdata_full, 32'h0);
        step(1'b1, 1'b0, 1'b1, 9'(($urandom % 512)), 32'h0);
        step(1'b0, 1'b0, 1'b0, 9'd5, 32'h0);
        check("reset_release_hold", rdata_full, 32'h0);

        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 9'(i), prog[i]);
        check("load_no_read", rdata_full, 32'h0);

        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 9'(i), 32'h0);
            check("fetch", rdata_full, prog[i]);
            if (i == 2) begin
                check("icode", 32'(rdata_full[31:28]), 32'd2);
                check("ifun",  32'(rdata_full[27:24]), 32'd1);
                check("rA",    32'(rdata_full[23:20]), 32'd2);
                check("rB",    32'(rdata_full[19:16]), 32'd3);
                check("valC",  32'(rdata_full[15:0]),  32'h0);
            end
        end

        step(1'b0, 1'b0, 1'b1, 9'd3, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 9'd0, 32'h0);
            check("hold", rdata_full, 32'h22450000);
        end

        step(1'b0, 1'b1, 1'b0, 9'd7, 32'hAAAAAAAA);
        step(1'b0, 1'b1, 1'b1, 9'd7, 32'h55555555);
`ifdef RAM_WR_BYPASS_EN
        check("collision", rdata_full, 32'h55555555);
`else
        check("collision", rdata_full, 32'hAAAAAAAA);
`endif
        step(1'b0, 1'b0, 1'b1, 9'd7, 32'h0);
        check("after_collision", rdata_full, 32'h55555555);

        step(1'b1, 1'b1, 1'b0, 9'd1, 32'hDEADBEEF);
        check("reset_mid", rdata_full, 32'h0);
        step(1'b0, 1'b0, 1'b1, 9'd1, 32'h0);
        check("reset_blocks_wr", rdata_full, 32'h20010000);

        step(1'b0, 1'b1, 1'b0, 9'd511, 32'h12345678);
        step(1'b0, 1'b0, 1'b1, 9'd511, 32'h0);
        check("oor_read_500", rdata_500, 32'h0);
        check("top_read_512", rdata_full, 32'h12345678);
        step(1'b0, 1'b1, 1'b0, 9'd499, 32'hCAFEF00D);
        step(1'b0, 1'b0, 1'b1, 9'd499, 32'h0);
        check("last_word_500", rdata_500, 32'hCAFEF00D);
        step(1'b0, 1'b1, 1'b1, 9'd500, 32'h0BADF00D);
        check("oor_wr_rd_500", rdata_500, 32'h0);

        // Random traffic, biased toward a small window and the range edge.
        for (int n = 0; n < 400; n++) begin
            logic [8:0] a;
            case ($urandom % 3)
                0:       a = 9'($urandom % 16);
                1:       a = 9'(496 + ($urandom % 16));
                default: a = 9'($urandom % 512);
            endcase
            step(($urandom % 40) == 0, ($urandom % 2) == 1, ($urandom % 2) == 1,
                 a, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
